// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the instruction address and steps it by
// increment, jump, conditional relative branch, call and return (LIFO stack).
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    OFFSET_WIDTH = 8,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               input_Clock,
  input  logic                               input_Reset,
  input  logic                               input_Stall,
  input  logic [2:0]                         input_Op,
  input  logic                               input_Cond,
  input  logic [ADDR_WIDTH-1:0]              input_Target,
  input  logic [OFFSET_WIDTH-1:0]            input_Offset,
  output logic [ADDR_WIDTH-1:0]              output_PC,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   output_Depth,
  output logic                               output_Overflow,
  output logic                               output_Underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  // Sign-extend the branch offset to the address width.
  function automatic logic signed [ADDR_WIDTH-1:0] sext_offset(
    input logic signed [OFFSET_WIDTH-1:0] off
  );
    return ADDR_WIDTH'(off);
  endfunction

  // Address add that wraps modulo 2^ADDR_WIDTH (no saturation on a PC).
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(
    input logic        [ADDR_WIDTH-1:0] base,
    input logic signed [ADDR_WIDTH-1:0] delta
  );
    logic signed [ADDR_WIDTH-1:0] sum;
    sum = $signed(base) + delta;
    return $unsigned(sum);
  endfunction

  logic [ADDR_WIDTH-1:0]  pc_p1;
  logic [DEPTH_W-1:0]     depth_p1;
  logic                   ovf_p1;
  logic                   unf_p1;

  // Indexed by the full depth count; entries at or above depth are never read.
  logic [ADDR_WIDTH-1:0]  stack_mem [2**DEPTH_W];

  logic                   vld_p0;
  logic                   push_p0;
  logic                   stack_full_p0;
  logic                   stack_empty_p0;
  logic [DEPTH_W-1:0]     top_idx_p0;
  logic [ADDR_WIDTH-1:0]  pc_inc_p0;
  logic [ADDR_WIDTH-1:0]  pc_br_p0;
  logic [ADDR_WIDTH-1:0]  pc_nxt_p0;
  logic [DEPTH_W-1:0]     depth_nxt_p0;
  logic                   ovf_nxt_p0;
  logic                   unf_nxt_p0;

  // Stage 0: decode the op against the current PC and stack occupancy.
  assign vld_p0         = ~input_Stall;
  assign stack_full_p0  = (depth_p1 == DEPTH_FULL);
  assign stack_empty_p0 = (depth_p1 == '0);
  assign top_idx_p0     = depth_p1 - DEPTH_ONE;
  assign pc_inc_p0      = wrap_add(pc_p1, ADDR_WIDTH'(1));
  assign pc_br_p0       = wrap_add(pc_p1, sext_offset($signed(input_Offset)));

  always_comb begin
    pc_nxt_p0    = pc_p1;
    depth_nxt_p0 = depth_p1;
    ovf_nxt_p0   = ovf_p1;
    unf_nxt_p0   = unf_p1;
    push_p0      = 1'b0;
    unique case (input_Op)
      OP_INC:    pc_nxt_p0 = pc_inc_p0;
      OP_JUMP:   pc_nxt_p0 = input_Target;
      OP_BRANCH: pc_nxt_p0 = input_Cond ? pc_br_p0 : pc_inc_p0;
      OP_CALL: begin
        if (stack_full_p0) begin
          ovf_nxt_p0 = 1'b1;
        end else begin
          push_p0      = vld_p0 & ~input_Reset;
          pc_nxt_p0    = input_Target;
          depth_nxt_p0 = depth_p1 + DEPTH_ONE;
        end
      end
      OP_RET: begin
        if (stack_empty_p0) begin
          unf_nxt_p0 = 1'b1;
        end else begin
          pc_nxt_p0    = stack_mem[top_idx_p0];
          depth_nxt_p0 = top_idx_p0;
        end
      end
      default: ;
    endcase
  end

  // Stage 1: architectural state; reset outranks stall and every op.
  always_ff @(posedge input_Clock) begin
    if (input_Reset) begin
      pc_p1    <= RESET_VECTOR;
      depth_p1 <= '0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else if (vld_p0) begin
      pc_p1    <= pc_nxt_p0;
      depth_p1 <= depth_nxt_p0;
      ovf_p1   <= ovf_nxt_p0;
      unf_p1   <= unf_nxt_p0;
    end
  end

  always_ff @(posedge input_Clock) begin
    if (push_p0) begin
      stack_mem[depth_p1] <= pc_inc_p0;
    end
  end

  assign output_PC        = pc_p1;
  assign output_Depth     = depth_p1;
  assign output_Overflow  = ovf_p1;
  assign output_Underflow = unf_p1;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model compared every cycle,
// plus directed literal checks and a randomized op stream.
module tb_pc_sequencer;

  localparam int AW = 8;
  localparam int OW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);
  localparam int AMOD = 1 << AW;
  localparam int OMOD = 1 << OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          cond = 1'b0;
  logic [AW-1:0] tgt = '0;
  logic [OW-1:0] off = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] depth;
  logic          ovf;
  logic          unf;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD), .RESET_VECTOR('0)
  ) dut (
    .input_Clock(clk), .input_Reset(rst), .input_Stall(stall), .input_Op(op),
    .input_Cond(cond), .input_Target(tgt), .input_Offset(off),
    .output_PC(pc), .output_Depth(depth), .output_Overflow(ovf),
    .output_Underflow(unf)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_pc = 0;
  int m_stack[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer mod 2^AW, stack as a queue.
  always @(posedge clk) begin
    int soff;
    if (rst) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      case (op)
        3'd0: m_pc = (m_pc + 1) % AMOD;
        3'd1: m_pc = int'(tgt);
        3'd2: begin
          soff = (int'(off) >= OMOD / 2) ? int'(off) - OMOD : int'(off);
          m_pc = cond ? (m_pc + soff + AMOD) % AMOD : (m_pc + 1) % AMOD;
        end
        3'd3: begin
          if (m_stack.size() == SD) m_ovf = 1'b1;
          else begin
            m_stack.push_back((m_pc + 1) % AMOD);
            m_pc = int'(tgt);
          end
        end
        3'd4: begin
          if (m_stack.size() == 0) m_unf = 1'b1;
          else m_pc = m_stack.pop_back();
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", int'(pc), m_pc);
      check("model_depth", int'(depth), m_stack.size());
      check("model_ovf", int'(ovf), int'(m_ovf));
      check("model_unf", int'(unf), int'(m_unf));
    end
  end

  task automatic drive(input bit r, input bit s, input logic [2:0] o,
                       input bit c, input logic [AW-1:0] t, input logic [OW-1:0] f);
    rst = r; stall = s; op = o; cond = c; tgt = t; off = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [AW-1:0] t = '0,
                       input logic [OW-1:0] f = '0, input bit c = 1'b0);
    drive(1'b0, 1'b0, o, c, t, f);
  endtask

  task automatic expect_state(input string name, input int e_pc, input int e_depth,
                              input int e_ovf, input int e_unf);
    check({name, "_pc"}, int'(pc), e_pc);
    check({name, "_depth"}, int'(depth), e_depth);
    check({name, "_ovf"}, int'(ovf), e_ovf);
    check({name, "_unf"}, int'(unf), e_unf);
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
    chk_en = 1'b1;
    expect_state("reset", 0, 0, 0, 0);

    do_op(3'd0); check("inc1", int'(pc), 1);
    do_op(3'd0); check("inc2", int'(pc), 2);
    do_op(3'd0); check("inc3", int'(pc), 3);
    do_op(3'd1, 8'hFF); check("jump_ff", int'(pc), 8'hFF);
    do_op(3'd0); expect_state("inc_wrap", 0, 0, 0, 0);

    do_op(3'd1, 8'h10);
    do_op(3'd2, '0, 8'hFC, 1'b1); check("br_back", int'(pc), 8'h0C);
    do_op(3'd2, '0, 8'h05, 1'b0); check("br_not_taken", int'(pc), 8'h0D);
    do_op(3'd1, 8'h02);
    do_op(3'd2, '0, 8'hFC, 1'b1); check("br_wrap", int'(pc), 8'hFE);

    do_op(3'd1, 8'h20);
    do_op(3'd3, 8'h40); expect_state("call1", 8'h40, 1, 0, 0);
    do_op(3'd3, 8'h60); expect_state("call2", 8'h60, 2, 0, 0);
    do_op(3'd4);        expect_state("ret1", 8'h41, 1, 0, 0);
    do_op(3'd4);        expect_state("ret2", 8'h21, 0, 0, 0);

    drive(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
    do_op(3'd3, 8'h80);
    do_op(3'd3, 8'h81);
    do_op(3'd3, 8'h82);
    do_op(3'd3, 8'h83); expect_state("fill", 8'h83, 4, 0, 0);
    do_op(3'd3, 8'h84); expect_state("overflow", 8'h83, 4, 1, 0);
    do_op(3'd4); expect_state("pop4", 8'h83, 3, 1, 0);
    do_op(3'd4); expect_state("pop3", 8'h82, 2, 1, 0);
    do_op(3'd4); expect_state("pop2", 8'h81, 1, 1, 0);
    do_op(3'd4); expect_state("pop1", 8'h01, 0, 1, 0);
    do_op(3'd4); expect_state("underflow", 8'h01, 0, 1, 1);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3'd3, 1'b0, 8'h30, '0);
      expect_state("stall", 8'h01, 0, 1, 1);
    end
    do_op(3'd3, 8'h30); expect_state("stall_release", 8'h30, 1, 1, 1);
    do_op(3'd5); expect_state("nop", 8'h30, 1, 1, 1);

    drive(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
    do_op(3'd3, 8'h10);
    do_op(3'd3, 8'h20);
    do_op(3'd3, 8'h30);
    do_op(3'd3, 8'h40);
    do_op(3'd3, 8'h50);
    do_op(3'd4);
    do_op(3'd4); do_op(3'd3, 8'h70); expect_state("ret_then_call", 8'h70, 3, 1, 0);
    do_op(3'd1, 8'h55); expect_state("mid_seq", 8'h55, 3, 1, 0);
    drive(1'b1, 1'b1, 3'd4, 1'b0, '0, '0); expect_state("reset_prio", 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            AW'($urandom), OW'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the microprocessor datapath. It holds the current instruction address and computes the next one from a decoded sequencing opcode: increment, absolute jump, conditional relative branch, subroutine call and return. Calls and returns use an internal return-address stack. The block replaces a bare PC register. Instruction memory reads `output_PC`, and the control unit drives `input_Op` each cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: width of PC, target and return addresses.
- `OFFSET_WIDTH`, 8: width of signed branch offset; `2 <= OFFSET_WIDTH <= ADDR_WIDTH`.
- `STACK_DEPTH`, 4: return-stack entries, ≥1.
- `RESET_VECTOR`, 0: PC value after reset.

Ports:
- `input_Clock`  in  1  sole clock; all state updates on rising edge.
- `input_Reset`  in  1  synchronous, active-high reset.
- `input_Stall`  in  1  1 = hold all state this cycle.
- `input_Op`  in  3  sequencing opcode (see Operation).
- `input_Cond`  in  1  branch-taken condition for BRANCH.
- `input_Target`  in  ADDR_WIDTH  absolute address for JUMP/CALL.
- `input_Offset`  in  OFFSET_WIDTH  two's-complement offset for BRANCH.
- `output_PC`  out  ADDR_WIDTH  current instruction address (registered).
- `output_Depth`  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- `output_Overflow`  out  1  sticky: CALL attempted with stack full.
- `output_Underflow`  out  1  sticky: RET attempted with stack empty.

## Operation
Opcodes are applied only when `input_Stall`=0 and `input_Reset`=0:
- 000 INC: PC ← PC+1.
- 001 JUMP: PC ← `input_Target`.
- 010 BRANCH: if `input_Cond`, PC ← PC + sext(`input_Offset`); else PC ← PC+1.
- 011 CALL: push PC+1; PC ← `input_Target`; depth +1.
- 100 RET: PC ← top of stack; pop; depth −1.
- 101, 110, 111 NOP: PC and stack unchanged; flags unchanged.

Arithmetic rules:
- All PC arithmetic is modulo 2^ADDR_WIDTH.
- The offset is sign-extended to ADDR_WIDTH before the add.
- The pushed return address wraps too: PC=all-ones pushes 0.

Stack rules:
- The stack is LIFO, and top is the entry written most recently.
- Entries beyond `output_Depth` are don't-care and never observable.

Error cases (faulting ops leave the PC unchanged):
- CALL with depth = STACK_DEPTH: no push, PC holds, depth holds, `output_Overflow` ← 1.
- RET with depth = 0: PC holds, depth holds, `output_Underflow` ← 1.
- Error flags stay set until reset. Later valid ops execute normally while a flag is set.

Stall:
- With `input_Stall`=1, PC, stack, depth and flags all hold, regardless of `input_Op`.

Reset:
- Sets PC ← RESET_VECTOR, depth ← 0, both flags ← 0.
- Reset has priority over stall and any op, including an in-progress call sequence.
- Stack contents need not be cleared.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Op sampled at rising edge N takes effect on `output_PC`/`output_Depth`/flags after edge N. Latency is one cycle; one op can be accepted per cycle.
- CALL immediately followed by RET: the RET sees the pushed entry and returns PC = call-site+1 one cycle later. Back-to-back push/pop needs no bubble.
- RET immediately followed by CALL: the CALL reuses the freed slot with no overflow.
- `input_Reset` is sampled at the clock edge only. Asserting it mid-cycle has no effect until the next rising edge. Outputs show reset values after that edge.

## Test plan
Defaults for all scenarios: ADDR_WIDTH=8, OFFSET_WIDTH=8, STACK_DEPTH=4, RESET_VECTOR=0.
- Reset, then 3×INC: PC reads 0, 1, 2, 3. Next JUMP target 0xFF, then INC: PC=0xFF, then 0x00 (wrap). Depth stays 0.
- PC=0x10: BRANCH offset 0xFC, cond=1 → PC=0x0C. BRANCH offset 0x05, cond=0 → PC=0x0D. PC=0x02: BRANCH offset 0xFC, cond=1 → PC=0xFE.
- PC=0x20: CALL 0x40 → PC=0x40, depth 1. CALL 0x60 → PC=0x60, depth 2. RET → PC=0x41, depth 1. RET → PC=0x21, depth 0. No flags set.
- Five CALLs to 0x80, 0x81, 0x82, 0x83, 0x84 from PC=0: the fifth sets Overflow, PC stays 0x83, depth 4. Then RET → PC=0x83+1=0x84? No: it pops 0x83's caller entry, PC=0x83. Required check: pushed values are 0x01, 0x81, 0x82, 0x83 and pop in reverse order. RET on empty → Underflow=1, PC holds.
- Stall=1 with Op=CALL for 3 cycles: PC, depth and flags unchanged. Release stall: the CALL executes one cycle later.
- Mid-sequence (depth 3, Overflow=1, PC=0x55): Reset together with Stall=1 and Op=RET → after the edge PC=0x00, depth 0, both flags 0.
